// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sweeps the selected ALU codes over latched operands and streams each result
// Optional feature: define ALU_OP_SEQUENCER_CHECKSUM_EN to add the checksum output (XOR of handshaken results).
// Each op spends one cycle loading alu_a/alu_b/alu_code, then SETTLE_CYCLES cycles settling before capture,
// which gives SETTLE_CYCLES+1 cycles from an accepted start or a handshake to res_valid.

module alu_op_sequencer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [7:0] op_mask,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_code,
   input  logic [7:0] alu_result,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [2:0] res_code,
   output logic       busy,
   output logic       done
`ifdef ALU_OP_SEQUENCER_CHECKSUM_EN
   ,
   output logic [7:0] checksum
`endif
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      OUTPUT = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [7:0] rem_q, rem_d;       // mask bits not yet issued in this sweep
   logic [2:0] code_q, code_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] alu_a_q, alu_a_d;
   logic [3:0] alu_b_q, alu_b_d;
   logic [2:0] alu_code_q, alu_code_d;
   logic [7:0] res_data_q, res_data_d;
   logic [2:0] res_code_q, res_code_d;
   logic       res_valid_q, res_valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] pick_src;
   logic [3:0] pick;               // {found, lowest set index}

   // Lowest set bit of a mask, so codes come out in ascending order.
   function automatic logic [3:0] first_set(input logic [7:0] m);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) begin
            r = {1'b1, 3'(i)};
         end
      end
      return r;
   endfunction

   // Next-state and next-output computation for the sweep FSM.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      rem_d       = rem_q;
      code_d      = code_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_code_d  = alu_code_q;
      res_data_d  = res_data_q;
      res_code_d  = res_code_q;
      pick_src    = (state_q == IDLE) ? op_mask : rem_q;
      pick        = first_set(pick_src);

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d   = a;
               b_d   = b;
               cnt_d = 4'd0;
               rem_d = pick_src & ~(8'd1 << pick[2:0]);
               if (pick[3]) begin
                  code_d  = pick[2:0];
                  state_d = DRIVE;
               end else begin
                  rem_d   = 8'd0;
                  state_d = DONE;
               end
            end
         end
         DRIVE: begin
            if (cnt_q == 4'd0) begin
               alu_a_d    = a_q;
               alu_b_d    = b_q;
               alu_code_d = code_q;
            end
            if (cnt_q == SETTLE_LAST) begin
               res_data_d = alu_result;
               res_code_d = code_q;
               state_d    = OUTPUT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         OUTPUT: begin
            if (res_ready) begin
               cnt_d = 4'd0;
               if (pick[3]) begin
                  code_d  = pick[2:0];
                  rem_d   = pick_src & ~(8'd1 << pick[2:0]);
                  state_d = DRIVE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      res_valid_d = (state_d == OUTPUT);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   // State and registered outputs; reset aborts any sweep without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= 4'd0;
         b_q         <= 4'd0;
         rem_q       <= 8'd0;
         code_q      <= 3'd0;
         cnt_q       <= 4'd0;
         alu_a_q     <= 4'd0;
         alu_b_q     <= 4'd0;
         alu_code_q  <= 3'd0;
         res_data_q  <= 8'd0;
         res_code_q  <= 3'd0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rem_q       <= rem_d;
         code_q      <= code_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_code_q  <= alu_code_d;
         res_data_q  <= res_data_d;
         res_code_q  <= res_code_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_code  = alu_code_q;
   assign res_data  = res_data_q;
   assign res_code  = res_code_q;
   assign res_valid = res_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef ALU_OP_SEQUENCER_CHECKSUM_EN
   logic [7:0] chk_q, chk_d;

   // Checksum restarts on an accepted start and folds in every handshaken result.
   always_comb begin
      chk_d = chk_q;
      if (state_q == IDLE && start) begin
         chk_d = 8'd0;
      end else if (state_q == OUTPUT && res_ready) begin
         chk_d = chk_q ^ res_data_q;
      end
   end

   // Checksum register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_q <= 8'd0;
      end else begin
         chk_q <= chk_d;
      end
   end

   assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a reference 8-op ALU

module tb_alu_op_sequencer;

   localparam int S1 = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;
   logic [7:0] op_mask = 8'd0;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_code;
   logic [7:0] alu_result;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_data;
   logic [2:0] res_code;
   logic       busy, done;
`ifdef ALU_OP_SEQUENCER_CHECKSUM_EN
   logic [7:0] checksum, s3_checksum;
`endif

   logic       s3_start = 1'b0;
   logic [3:0] s3_alu_a, s3_alu_b;
   logic [2:0] s3_alu_code;
   logic [7:0] s3_alu_result;
   logic       s3_res_valid;
   logic [7:0] s3_res_data;
   logic [2:0] s3_res_code;
   logic       s3_busy, s3_done;

   int checks = 0;
   int errors = 0;
   int ready_mode = 0;
   int held = 0;
   int done_cnt = 0;
   int lat_cnt = 0;
   int vcyc = 0;
   logic [10:0] sb_q[$];
   logic        prev_valid = 1'b0, prev_hs = 1'b0, hs;
   logic [7:0]  prev_data = 8'd0;
   logic [2:0]  prev_code = 3'd0, prev_alu_code = 3'd0;
   logic [10:0] e;
   logic [7:0]  tbl [8] = '{8'h09, 8'hFF, 8'hFB, 8'h14, 8'h04, 8'h05, 8'hFB, 8'hFA};

   function automatic logic [7:0] ref_alu(input logic [2:0] c, input logic [3:0] x, input logic [3:0] y);
      logic [7:0] xa, yb;
      xa = {4'd0, x};
      yb = {4'd0, y};
      case (c)
         3'd0:    return xa + yb;
         3'd1:    return xa - yb;
         3'd2:    return ~xa;
         3'd3:    return xa * yb;
         3'd4:    return xa & yb;
         3'd5:    return xa | yb;
         3'd6:    return ~(xa & yb);
         default: return ~(xa | yb);
      endcase
   endfunction

   assign alu_result    = ref_alu(alu_code, alu_a, alu_b);
   assign s3_alu_result = ref_alu(s3_alu_code, s3_alu_a, s3_alu_b);

   always #5 clk = ~clk;

   alu_op_sequencer #(.SETTLE_CYCLES(S1)) dut (
`ifdef ALU_OP_SEQUENCER_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .op_mask    (op_mask),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_code   (alu_code),
      .alu_result (alu_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_code   (res_code),
      .busy       (busy),
      .done       (done)
   );

   alu_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (
`ifdef ALU_OP_SEQUENCER_CHECKSUM_EN
      .checksum   (s3_checksum),
`endif
      .clk        (clk),
      .rst        (rst),
      .start      (s3_start),
      .a          (4'd4),
      .b          (4'd5),
      .op_mask    (8'h05),
      .alu_a      (s3_alu_a),
      .alu_b      (s3_alu_b),
      .alu_code   (s3_alu_code),
      .alu_result (s3_alu_result),
      .res_valid  (s3_res_valid),
      .res_ready  (1'b1),
      .res_data   (s3_res_data),
      .res_code   (s3_res_code),
      .busy       (s3_busy),
      .done       (s3_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // res_ready driver: 0 always high, 1 random, 2 high only after 5 valid cycles, other always low
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: res_ready = 1'b1;
         1: res_ready = 1'($urandom_range(0, 1));
         2: begin
            if (res_valid) held++;
            else held = 0;
            res_ready = (held >= 5);
         end
         default: res_ready = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard on each handshake, checks latency, hold stability and done
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
         vcyc       = 0;
         lat_cnt    = 0;
      end else begin
         lat_cnt++;
         if (res_valid && !prev_valid) check("latency", lat_cnt, S1 + 1);
         if (prev_valid && !prev_hs) begin
            check("hold_valid", res_valid, 1'b1);
            check("hold_data", res_data, prev_data);
            check("hold_code", res_code, prev_code);
            check("hold_alu_code", alu_code, prev_alu_code);
         end
         if (res_valid) vcyc++;
         hs = res_valid && res_ready;
         if (hs) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual=%0h expected=none", res_data);
            end else begin
               e = sb_q.pop_front();
               check("res_code", res_code, e[10:8]);
               check("res_data", res_data, e[7:0]);
            end
            if (ready_mode == 2) check("held_cycles", vcyc, 5);
            vcyc = 0;
         end
         if (done) begin
            done_cnt++;
            check("done_sb_empty", sb_q.size(), 0);
            check("done_busy", busy, 1'b1);
         end
         if (hs || (start && !busy)) lat_cnt = -1;
         prev_valid    = res_valid;
         prev_hs       = hs;
         prev_data     = res_data;
         prev_code     = res_code;
         prev_alu_code = alu_code;
      end
   end

   task automatic do_sweep(input logic [3:0] xa, input logic [3:0] xb, input logic [7:0] m,
                           input int mode, input bit use_table, input bit poke);
      int n, cyc, d0;
      bit saw_valid;
      ready_mode = mode;
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      for (int c = 0; c < 8; c++) begin
         if (m[c]) sb_q.push_back({3'(c), use_table ? tbl[c] : ref_alu(3'(c), xa, xb)});
      end
      d0 = done_cnt;
      saw_valid = 1'b0;
      start = 1'b1;
      a = xa;
      b = xb;
      op_mask = m;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            start   = 1'b0;
            a       = 4'($urandom);
            b       = 4'($urandom);
            op_mask = 8'($urandom);
         end
         if (poke && cyc == 3) begin
            start = 1'b1;
            a     = 4'hF;
         end
         if (poke && cyc == 4) start = 1'b0;
         if (res_valid) saw_valid = 1'b1;
      end while (!done && cyc < 400);
      check("done_seen", done, 1'b1);
      if (m == 8'd0) check("empty_done_latency", cyc, 1);
      check("saw_valid", saw_valid, m != 8'd0);
      @(posedge clk); #1;
      check("idle_after_done", busy, 1'b0);
      check("done_one_cycle", done, 1'b0);
      check("done_count", done_cnt - d0, 1);
      if (sb_q.size() != 0) begin
         check("sb_drained", sb_q.size(), 0);
         sb_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cyc, cnt2;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_valid", res_valid, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_alu", {alu_a, alu_b, alu_code}, 0);
      check("rst_res", {res_data, res_code}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", busy, 1'b0);

      // Full sweep against the fixed table, then ALU outputs hold in IDLE
      do_sweep(4'd4, 4'd5, 8'hFF, 0, 1'b1, 1'b0);
      check("hold_alu_a_idle", alu_a, 4'd4);
      check("hold_alu_b_idle", alu_b, 4'd5);
      check("hold_alu_code_idle", alu_code, 3'd7);
`ifdef ALU_OP_SEQUENCER_CHECKSUM_EN
      check("checksum", checksum, 8'h19);
`endif

      // Empty mask, slow consumer, start while busy
      do_sweep(4'd4, 4'd5, 8'h00, 0, 1'b0, 1'b0);
      do_sweep(4'd4, 4'd5, 8'h81, 2, 1'b0, 1'b0);
      do_sweep(4'd4, 4'd5, 8'hFF, 0, 1'b1, 1'b1);

      // Reset while a result is waiting in OUTPUT
      ready_mode = 3;
      start = 1'b1; a = 4'd4; b = 4'd5; op_mask = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!res_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("reach_output", res_valid, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", res_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_outs", {alu_a, alu_b, alu_code, res_data, res_code, done}, 0);
      cnt2 = done_cnt;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_no_done", done_cnt - cnt2, 0);
      check("mid_rst_done_low", done, 1'b0);
      do_sweep(4'd3, 4'd2, 8'h01, 0, 1'b0, 1'b0);

      // Randomized sweeps
      for (int i = 0; i < 25; i++) begin
         do_sweep(4'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      // SETTLE_CYCLES=3 instance: latency and alu_code hold per op
      s3_start = 1'b1;
      @(posedge clk); #1;
      s3_start = 1'b0;
      cyc = 0;
      while (!s3_res_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("s3_first_latency", cyc, 4);
      check("s3_first_data", s3_res_data, 8'h09);
      check("s3_first_code", s3_res_code, 3'd0);
      @(posedge clk); #1;
      check("s3_valid_drop", s3_res_valid, 1'b0);
      cyc = 0;
      cnt2 = 0;
      while (!s3_res_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (s3_alu_code == 3'd2 && !s3_res_valid) cnt2++;
      end
      check("s3_second_latency", cyc, 4);
      check("s3_code_hold", cnt2, 3);
      check("s3_second_data", s3_res_data, 8'hFB);
      check("s3_second_code", s3_res_code, 3'd2);
      n = 0;
      while (!s3_done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("s3_done", s3_done, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: cycles operands/code are held on the ALU before capture; legal 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a sweep; accepted only when busy=0.
REQ-005 SHALL have port a  input  4  operand A, latched on accepted start.
REQ-006 SHALL have port b  input  4  operand B, latched on accepted start.
REQ-007 SHALL have port op_mask  input  8  bit n set = run ALU code n; latched on accepted start.
REQ-008 SHALL have port alu_a  output  4  operand A driven to the ALU.
REQ-009 SHALL have port alu_b  output  4  operand B driven to the ALU.
REQ-010 SHALL have port alu_code  output  3  operation code driven to the ALU.
REQ-011 SHALL have port alu_result  input  8  combinational ALU result.
REQ-012 SHALL have port res_valid  output  1  res_data/res_code valid.
REQ-013 SHALL have port res_ready  input  1  downstream accepts result.
REQ-014 SHALL have port res_data  output  8  captured ALU result.
REQ-015 SHALL have port res_code  output  3  code that produced res_data.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at sweep end.

Function
REQ-018 SHALL implement FSM states IDLE, DRIVE, OUTPUT, DONE.
REQ-019 IDLE: start=1 latches a, b, op_mask; next state DRIVE at lowest set mask bit, or DONE if op_mask=0.
REQ-020 DRIVE: alu_a/alu_b = latched operands, alu_code = current code; stay exactly SETTLE_CYCLES cycles; on last cycle's edge capture alu_result into res_data, code into res_code; go OUTPUT.
REQ-021 OUTPUT: res_valid=1; res_data, res_code, alu_* stable until res_valid&res_ready edge.
REQ-022 On handshake: next higher set mask bit -> DRIVE with that code; none remaining -> DONE.
REQ-023 DONE: done=1, busy=1 for exactly one cycle, then IDLE.
REQ-024 Codes SHALL be issued in ascending order 0..7; unset bits skipped with no extra cycles.
REQ-025 Latency: res_valid rises SETTLE_CYCLES+1 cycles after accepted start edge; after each handshake, next res_valid rises SETTLE_CYCLES+1 cycles later.
REQ-026 start while busy=1 SHALL be ignored; latched operands/mask unaffected by input changes mid-sweep.
REQ-027 res_ready=1 outside OUTPUT SHALL have no effect; res_valid SHALL not drop without handshake.
REQ-028 In IDLE/DONE alu_a, alu_b, alu_code SHALL hold last driven values (0 after reset).

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, latched regs 0, alu_a=0, alu_b=0, alu_code=0, res_data=0, res_code=0, res_valid=0, busy=0, done=0.
REQ-030 Reset mid-sweep SHALL abort without done pulse; first start after release begins a fresh sweep.

Configuration
REQ-031 Macro ALU_OP_SEQUENCER_CHECKSUM_EN defined: adds output checksum (8) = XOR of all handshaken res_data of the current sweep, cleared to 0 on accepted start and on reset, stable from done until next accepted start.
REQ-032 Macro undefined: checksum port and its logic SHALL be absent; all other behaviour identical.

Verification (bench connects a reference 8-op ALU: add, sub, not-A, mul, and, or, nand, nor on zero-extended operands)
REQ-033 a=4, b=5, op_mask=FF, res_ready=1, SETTLE=1 -> res_data sequence 09,FF,FB,14,04,05,FB,FA with res_code 0..7, then one done pulse; checksum=19 when enabled.
REQ-034 op_mask=00 -> done pulses on cycle after start edge, res_valid never asserts.
REQ-035 op_mask=81, res_ready low 5 cycles per result -> only codes 0 and 7 output, each held stable 5 cycles before handshake.
REQ-036 start pulsed again mid-sweep with a=F -> ignored; results still use a=4.
REQ-037 rst asserted during OUTPUT -> all outputs 0 immediately, no done; following start with a=3, b=2, mask=01 -> res_data=05.
REQ-038 SETTLE_CYCLES=3 -> res_valid rises 4 cycles after start edge, alu_code held 3 cycles per op.
